// File: rtl/ddr_wr_channel.sv
// ddr_wr_channel: buffers a 256-bit beat stream in a first-word-fall-through
// FIFO and issues DDR write bursts of up to BURST_LEN beats. Burst addresses
// walk a frame buffer starting at cfg_base_addr. After cfg_frame_beats beats
// the address wraps back to the base, and frame_done pulses.
// Optional feature macro: DDR_WR_CHNL_FLUSH_EN. When it is defined, an accepted
// s_last flushes a short burst that holds every beat up to that s_last, and
// that burst ends the frame.
module ddr_wr_channel #(
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_LEN  = 32
) (
    input  logic         ui_clk,
    input  logic         ui_rst,
    input  logic [31:0]  cfg_base_addr,
    input  logic [31:0]  cfg_frame_beats,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [255:0] s_data,
    input  logic         s_last,
    output logic         wr_burst_req,
    output logic [31:0]  wr_burst_addr,
    output logic [9:0]   wr_burst_len,
    input  logic         wr_ready,
    input  logic         wr_fifo_re,
    output logic [255:0] wr_fifo_data,
    input  logic         wr_burst_finish,
    output logic         frame_done,
    output logic         underrun_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [9:0]    BLEN_C  = 10'(BURST_LEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // FIFO storage and pointers
    logic [255:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Burst sequencing state
    logic [1:0]  state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] burst_addr_q, burst_addr_d;
    logic [9:0]  burst_len_q, burst_len_d;
    logic [9:0]  popped_q, popped_d;
    logic        wrap_q, wrap_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;

    // Frame tracking; the cfg inputs are captured once per frame
    logic        frame_act_q, frame_act_d;
    logic [31:0] frame_base_q, frame_base_d;
    logic [31:0] frame_beats_q, frame_beats_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic [31:0] issued_q, issued_d;

`ifdef DDR_WR_CHNL_FLUSH_EN
    logic          flush_pend_q, flush_pend_d;
    logic [CW-1:0] flush_rem_q, flush_rem_d;
`endif

    logic        full_s, empty_s, push_s, pop_s, bad_re_s;
    logic [31:0] eff_beats_s, eff_addr_s, eff_issued_s, remain_s;
    logic [9:0]  l_norm_s, plan_len_s;
    logic        end_norm_s, plan_end_s, fire_s;
    logic        unused_s;

    assign full_s  = (count_q == DEPTH_C);
    assign empty_s = (count_q == '0);
    assign s_ready = !ui_rst && !full_s;
    assign push_s  = s_valid && s_ready;
    // A pull counts only inside a burst, with data present and fewer than L beats taken
    assign pop_s    = wr_fifo_re && (state_q == ST_REQ) && !empty_s && (popped_q < burst_len_q);
    assign bad_re_s = wr_fifo_re && !pop_s;

    assign wr_burst_req  = req_q;
    assign wr_burst_addr = burst_addr_q;
    assign wr_burst_len  = burst_len_q;
    assign frame_done    = frame_done_q;
    assign underrun_err  = underrun_q;

`ifdef DDR_WR_CHNL_FLUSH_EN
    assign unused_s = wr_ready;
`else
    assign unused_s = wr_ready ^ s_last;
`endif

    // Head of FIFO shown combinationally; zero when empty or on an illegal pull
    always_comb begin
        if (empty_s || bad_re_s) begin
            wr_fifo_data = '0;
        end else begin
            wr_fifo_data = mem_q[rd_ptr_q];
        end
    end

    // Plan the next burst: length L, start address and whether it closes the frame
    always_comb begin
        eff_beats_s  = frame_act_q ? frame_beats_q : cfg_frame_beats;
        eff_addr_s   = frame_act_q ? next_addr_q   : cfg_base_addr;
        eff_issued_s = frame_act_q ? issued_q      : 32'd0;
        remain_s     = eff_beats_s - eff_issued_s;
        if ((eff_beats_s == 32'd0) || (remain_s > 32'(BURST_LEN))) begin
            l_norm_s   = BLEN_C;
            end_norm_s = 1'b0;
        end else begin
            l_norm_s   = remain_s[9:0];
            end_norm_s = 1'b1;
        end
`ifdef DDR_WR_CHNL_FLUSH_EN
        if (flush_pend_q && (flush_rem_q != '0) && (32'(flush_rem_q) <= 32'(l_norm_s))) begin
            plan_len_s = 10'(flush_rem_q);
            plan_end_s = 1'b1;
        end else begin
            plan_len_s = l_norm_s;
            plan_end_s = end_norm_s;
        end
`else
        plan_len_s = l_norm_s;
        plan_end_s = end_norm_s;
`endif
        fire_s = (plan_len_s != 10'd0) && (32'(count_q) >= 32'(plan_len_s));
    end

    // Next-state logic for the FIFO, burst FSM and frame bookkeeping
    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        burst_addr_d  = burst_addr_q;
        burst_len_d   = burst_len_q;
        popped_d      = popped_q;
        wrap_d        = wrap_q;
        frame_done_d  = 1'b0;
        frame_act_d   = frame_act_q;
        frame_base_d  = frame_base_q;
        frame_beats_d = frame_beats_q;
        next_addr_d   = next_addr_q;
        issued_d      = issued_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(push_s) - CW'(pop_s);

        if (bad_re_s || (wr_burst_finish && (state_q != ST_REQ))) begin
            underrun_d = 1'b1;
        end else begin
            underrun_d = underrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fire_s) begin
                    state_d      = ST_REQ;
                    req_d        = 1'b1;
                    burst_addr_d = eff_addr_s;
                    burst_len_d  = plan_len_s;
                    popped_d     = 10'd0;
                    wrap_d       = plan_end_s;
                    if (!frame_act_q) begin
                        frame_act_d   = 1'b1;
                        frame_base_d  = cfg_base_addr;
                        frame_beats_d = cfg_frame_beats;
                        next_addr_d   = cfg_base_addr;
                        issued_d      = 32'd0;
                    end else begin
                        frame_act_d   = frame_act_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (pop_s) begin
                    popped_d = popped_q + 10'd1;
                end else begin
                    popped_d = popped_q;
                end
                if (wr_burst_finish) begin
                    state_d      = ST_DONE;
                    req_d        = 1'b0;
                    frame_done_d = wrap_q;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (wrap_q) begin
                    // Frame closed: next burst re-samples the cfg inputs
                    frame_act_d = 1'b0;
                    issued_d    = 32'd0;
                    next_addr_d = frame_base_q;
                end else begin
                    next_addr_d = next_addr_q + {17'd0, burst_len_q, 5'd0};
                    issued_d    = issued_q + 32'(burst_len_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

`ifdef DDR_WR_CHNL_FLUSH_EN
        flush_pend_d = flush_pend_q;
        flush_rem_d  = flush_rem_q;
        if ((state_q == ST_DONE) && wrap_q && (flush_rem_q == '0)) begin
            flush_pend_d = 1'b0;
        end else begin
            flush_pend_d = flush_pend_q;
        end
        if (push_s && s_last) begin
            // Everything buffered after this cycle belongs to the flushed frame tail
            flush_pend_d = 1'b1;
            flush_rem_d  = count_d;
        end else if (pop_s && (flush_rem_q != '0)) begin
            flush_rem_d = flush_rem_q - CW'(1);
        end else begin
            flush_rem_d = flush_rem_q;
        end
`endif
    end

    // FIFO data storage; contents need no reset because pointers define validity
    always_ff @(posedge ui_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge ui_clk or posedge ui_rst) begin
        if (ui_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            burst_addr_q  <= 32'd0;
            burst_len_q   <= 10'd0;
            popped_q      <= 10'd0;
            wrap_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
            frame_act_q   <= 1'b0;
            frame_base_q  <= 32'd0;
            frame_beats_q <= 32'd0;
            next_addr_q   <= 32'd0;
            issued_q      <= 32'd0;
`ifdef DDR_WR_CHNL_FLUSH_EN
            flush_pend_q  <= 1'b0;
            flush_rem_q   <= '0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            req_q         <= req_d;
            burst_addr_q  <= burst_addr_d;
            burst_len_q   <= burst_len_d;
            popped_q      <= popped_d;
            wrap_q        <= wrap_d;
            frame_done_q  <= frame_done_d;
            underrun_q    <= underrun_d;
            frame_act_q   <= frame_act_d;
            frame_base_q  <= frame_base_d;
            frame_beats_q <= frame_beats_d;
            next_addr_q   <= next_addr_d;
            issued_q      <= issued_d;
`ifdef DDR_WR_CHNL_FLUSH_EN
            flush_pend_q  <= flush_pend_d;
            flush_rem_q   <= flush_rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_ddr_wr_channel.sv
// Self-checking bench for ddr_wr_channel (default parameters 64/32).
// Reference: a queue of pushed beats plus a frame-level address/length model.
module tb_ddr_wr_channel;

    localparam int BL = 32;

    logic         ui_clk = 1'b0;
    logic         ui_rst;
    logic [31:0]  cfg_base_addr, cfg_frame_beats;
    logic         s_valid, s_ready, s_last;
    logic [255:0] s_data;
    logic         wr_burst_req;
    logic [31:0]  wr_burst_addr;
    logic [9:0]   wr_burst_len;
    logic         wr_ready, wr_fifo_re, wr_burst_finish;
    logic [255:0] wr_fifo_data;
    logic         frame_done, underrun_err;

    int errors = 0;
    int checks = 0;

    logic [255:0] q[$];
    bit           m_active, m_last;
    logic [31:0]  m_base, m_frame, m_issued, m_remain, exp_addr;
    int           exp_len;

    ddr_wr_channel #(.FIFO_DEPTH(64), .BURST_LEN(BL)) dut (
        .ui_clk(ui_clk), .ui_rst(ui_rst),
        .cfg_base_addr(cfg_base_addr), .cfg_frame_beats(cfg_frame_beats),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr), .wr_burst_len(wr_burst_len),
        .wr_ready(wr_ready), .wr_fifo_re(wr_fifo_re), .wr_fifo_data(wr_fifo_data),
        .wr_burst_finish(wr_burst_finish), .frame_done(frame_done), .underrun_err(underrun_err)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    task automatic push_beats(input int n, input bit with_last);
        int guard;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = rnd();
            s_last  = with_last && (i == n - 1);
            guard   = 0;
            while (!s_ready && guard < 100) begin
                tick();
                guard++;
            end
            if (!s_ready) check("push_timeout", s_ready, 1'b1);
            q.push_back(s_data);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Wait for a request and compare it with the frame-level expectation
    task automatic start_burst(input int flush_len, input string tag);
        for (int g = 0; g < 40 && wr_burst_req !== 1'b1; g++) tick();
        check({tag, "_req"}, wr_burst_req, 1'b1);
        if (!m_active) begin
            m_base   = cfg_base_addr;
            m_frame  = cfg_frame_beats;
            m_issued = 32'd0;
            m_active = 1'b1;
        end
        m_remain = m_frame - m_issued;
        exp_len  = (m_frame == 32'd0 || m_remain > 32'(BL)) ? BL : int'(m_remain);
        m_last   = (m_frame != 32'd0) && (m_remain <= 32'(BL));
        if (flush_len > 0 && flush_len <= exp_len) begin
            exp_len = flush_len;
            m_last  = 1'b1;
        end
        exp_addr = m_base + m_issued * 32;
        check({tag, "_addr"}, wr_burst_addr, exp_addr);
        check({tag, "_len"}, wr_burst_len, 10'(exp_len));
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            wr_fifo_re = 1'b1;
            #1;
            check("pop_data", wr_fifo_data, q.pop_front());
            tick();
        end
        wr_fifo_re = 1'b0;
    endtask

    task automatic finish_burst(input string tag);
        check({tag, "_held_len"}, wr_burst_len, 10'(exp_len));
        wr_burst_finish = 1'b1;
        tick();
        wr_burst_finish = 1'b0;
        check({tag, "_req_low"}, wr_burst_req, 1'b0);
        check({tag, "_frame_done"}, frame_done, m_last);
        m_issued = m_issued + 32'(exp_len);
        if (m_last) m_active = 1'b0;
        tick();
        check({tag, "_frame_done_end"}, frame_done, 1'b0);
    endtask

    task automatic apply_reset();
        ui_rst = 1'b1;
        s_valid = 1'b0;
        wr_fifo_re = 1'b0;
        wr_burst_finish = 1'b0;
        #1;
        q.delete();
        m_active = 1'b0;
        tick();
        ui_rst = 1'b0;
        #1;
    endtask

    initial begin
        ui_rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        wr_ready = 1'b1; wr_fifo_re = 1'b0; wr_burst_finish = 1'b0;
        cfg_base_addr = 32'h1000; cfg_frame_beats = 32'd64; m_active = 1'b0;
        #2;
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_req", wr_burst_req, 1'b0);
        check("rst_addr", wr_burst_addr, 32'd0);
        check("rst_len", wr_burst_len, 10'd0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_underrun", underrun_err, 1'b0);
        tick(); tick();
        ui_rst = 1'b0;
        #1;
        check("s_ready_after_rst", s_ready, 1'b1);

        // Frame of 64: two bursts, second one wraps
        push_beats(32, 1'b0);
        start_burst(0, "b1");
        pop_n(32);
        finish_burst("b1");
        push_beats(32, 1'b0);
        start_burst(0, "b2");
        pop_n(32);
        finish_burst("b2");

        // Frame of 40 at base again; mid-frame cfg changes are ignored
        cfg_frame_beats = 32'd40;
        push_beats(32, 1'b0);
        start_burst(0, "f40a");
        cfg_base_addr = 32'h9000;
        cfg_frame_beats = 32'd64;
        pop_n(32);
        finish_burst("f40a");
        push_beats(8, 1'b0);
        start_burst(0, "f40b");
        pop_n(8);
        finish_burst("f40b");

        // No-wrap frame near top of address space; FIFO full and simultaneous push/pop
        cfg_base_addr = 32'hFFFF_FC00;
        cfg_frame_beats = 32'd0;
        push_beats(64, 1'b0);
        start_burst(0, "full");
        s_valid = 1'b1;
        s_data  = rnd();
        check("full_s_ready", s_ready, 1'b0);
        wr_fifo_re = 1'b1;
        #1;
        check("full_pop_data", wr_fifo_data, q.pop_front());
        tick();
        check("after_pop_s_ready", s_ready, 1'b1);
        #1;
        check("pushpop_data", wr_fifo_data, q.pop_front());
        q.push_back(s_data);
        tick();
        check("pushpop_count_kept", s_ready, 1'b1);
        wr_fifo_re = 1'b0;
        s_data = rnd();
        q.push_back(s_data);
        tick();
        check("refull_s_ready", s_ready, 1'b0);
        s_valid = 1'b0;
        pop_n(30);
        wr_fifo_re = 1'b1;
        #1;
        check("extra_re_data", wr_fifo_data, 256'd0);
        tick();
        wr_fifo_re = 1'b0;
        check("extra_re_underrun", underrun_err, 1'b1);
        finish_burst("full");
        start_burst(0, "wrap32");
        pop_n(32);
        finish_burst("wrap32");
        check("underrun_sticky", underrun_err, 1'b1);

        // Finish while idle
        apply_reset();
        check("underrun_cleared", underrun_err, 1'b0);
        wr_burst_finish = 1'b1;
        tick();
        wr_burst_finish = 1'b0;
        check("idle_finish_underrun", underrun_err, 1'b1);
        check("idle_finish_req", wr_burst_req, 1'b0);
        apply_reset();

        // Reset in the middle of a burst
        cfg_base_addr = 32'h3000;
        cfg_frame_beats = 32'd64;
        push_beats(32, 1'b0);
        start_burst(0, "mid");
        pop_n(5);
        ui_rst = 1'b1;
        #1;
        check("midrst_req", wr_burst_req, 1'b0);
        check("midrst_s_ready", s_ready, 1'b0);
        check("midrst_len", wr_burst_len, 10'd0);
        q.delete();
        m_active = 1'b0;
        tick();
        ui_rst = 1'b0;
        #1;
        check("midrst_ready_after", s_ready, 1'b1);
        check("midrst_empty_data", wr_fifo_data, 256'd0);
        cfg_base_addr = 32'h3800;
        push_beats(32, 1'b0);
        start_burst(0, "fresh");
        pop_n(32);
        finish_burst("fresh");

        // s_last behaviour
        apply_reset();
        cfg_base_addr = 32'h5000;
        cfg_frame_beats = 32'd64;
`ifdef DDR_WR_CHNL_FLUSH_EN
        push_beats(5, 1'b1);
        start_burst(5, "flush");
        pop_n(5);
        finish_burst("flush");
        push_beats(32, 1'b0);
        start_burst(0, "after_flush");
        pop_n(32);
        finish_burst("after_flush");
`else
        push_beats(5, 1'b1);
        tick(); tick(); tick(); tick();
        check("last_ignored_req", wr_burst_req, 1'b0);
        push_beats(27, 1'b0);
        start_burst(0, "nolast");
        pop_n(32);
        finish_burst("nolast");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
